// File: rtl/bcd_result_decoder.sv
// Sequential double-dabble converter: turns a signed two's-complement result into
// sign, BCD magnitude digits and a significant-digit count, one shift per clock.
module bcd_result_decoder #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  nRST,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin_in,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  negative,
   output logic [2:0]            num_digits,
   output logic                  busy,
   output logic                  finish
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      DONE
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [WIDTH-1:0]     r_mag;
   logic [4*DIGITS-1:0]  r_scratch;
   logic                 r_neg;
   logic [CNT_W-1:0]     r_cnt;
   logic                 w_capture;
   logic                 w_step;
   logic                 w_load;
   logic [4*DIGITS-1:0]  w_adj;
   logic [2:0]           w_nd;

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = CONVERT;
         CONVERT: if (r_cnt == CNT_W'(WIDTH - 1)) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_capture = 1'b0;
      w_step    = 1'b0;
      w_load    = 1'b0;
      busy      = 1'b0;
      case (r_state)
         IDLE:    w_capture = start;
         CONVERT: begin w_step = 1'b1; busy = 1'b1; end
         DONE:    begin w_load = 1'b1; busy = 1'b1; end
         default: ;
      endcase
   end

   // Add-3 correction on every nibble that would overflow past 9 after the shift.
   always_comb begin
      w_adj = r_scratch;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_scratch[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      w_nd = 3'd1;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_scratch[4*i +: 4] != 4'd0) w_nd = 3'(i + 1);
      end
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         r_mag     <= '0;
         r_scratch <= '0;
         r_neg     <= 1'b0;
         r_cnt     <= '0;
      end else if (w_capture) begin
         r_mag     <= bin_in[WIDTH-1] ? -bin_in : bin_in;
         r_neg     <= bin_in[WIDTH-1];
         r_scratch <= '0;
         r_cnt     <= '0;
      end else if (w_step) begin
         r_scratch <= (w_adj << 1) | {{(4*DIGITS-1){1'b0}}, r_mag[WIDTH-1]};
         r_mag     <= r_mag << 1;
         r_cnt     <= r_cnt + CNT_W'(1);
      end
   end

   // Display-facing outputs only move on the DONE cycle, so they are stable mid-conversion.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         bcd_out    <= '0;
         negative   <= 1'b0;
         num_digits <= 3'd1;
         finish     <= 1'b0;
      end else begin
         finish <= w_load;
         if (w_load) begin
            bcd_out    <= r_scratch;
            negative   <= r_neg;
            num_digits <= w_nd;
         end
      end
   end

endmodule
